// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register, operand forwarding and RAW hazard stall for the 32-bit ALU.
// Latency: one cycle from decode inputs to EX outputs; forwarding muxes and id_stall are combinational.
// Backpressure: id_stall holds decode/PC and injects a bubble into EX; flush discards and overrides stall.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_*                             decoded instruction and register-file read data from ID
//   flush                            discard the instruction entering EX (branch redirect)
//   exm_valid/exm_wen/exm_rd/exm_d   EX/MEM writer and its ALU result
//   wb_valid/wb_wen/wb_rd/wb_data    MEM/WB writer and its write-back data
//   id_stall                         hold decode and PC this cycle
//   ex_valid, ex_a, ex_b, ex_S,
//   ex_Cin, ex_rd, ex_wen, ex_is_load  EX-stage outputs to the ALU and EX/MEM register
//
// Configuration macro FWD_EN:
//   defined   - EX/MEM and MEM/WB forwarding; only a load-use pair stalls (one cycle).
//   undefined - no forwarding; ID stalls while any valid writer in EX, EX/MEM or MEM/WB
//               targets a source register that the ID instruction reads.

module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic [31:0] id_imm,
    input  logic        id_use_imm,
    input  logic [2:0]  id_S,
    input  logic        id_Cin,
    input  logic [4:0]  id_rd,
    input  logic        id_wen,
    input  logic        id_is_load,
    input  logic        flush,
    input  logic        exm_valid,
    input  logic        exm_wen,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_d,
    input  logic        wb_valid,
    input  logic        wb_wen,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_S,
    output logic        ex_Cin,
    output logic [4:0]  ex_rd,
    output logic        ex_wen,
    output logic        ex_is_load
);

    logic        valid_q,   valid_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [31:0] rs1_val_q, rs1_val_d;
    logic [31:0] rs2_val_q, rs2_val_d;
    logic [31:0] imm_q,     imm_d;
    logic        use_imm_q, use_imm_d;
    logic [2:0]  s_q,       s_d;
    logic        cin_q,     cin_d;
    logic [4:0]  rd_q,      rd_d;
    logic        wen_q,     wen_d;
    logic        is_load_q, is_load_d;

    logic        hazard;
    logic [31:0] opa;
    logic [31:0] opb_reg;

    // A writer conflicts with the ID instruction when it targets a nonzero register
    // that ID actually reads (rs2 is unused when the immediate feeds operand b).
    function automatic logic raw_hit(input logic wr_vld, input logic [4:0] wr_rd);
        return wr_vld && (wr_rd != 5'd0) &&
               ((wr_rd == id_rs1) || (!id_use_imm && (wr_rd == id_rs2)));
    endfunction

`ifdef FWD_EN
    // Youngest producer wins: EX/MEM is checked before MEM/WB.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] reg_val);
        logic [31:0] res;
        res = reg_val;
        if (src != 5'd0) begin
            if (exm_valid && exm_wen && (exm_rd == src))
                res = exm_d;
            else if (wb_valid && wb_wen && (wb_rd == src))
                res = wb_data;
        end
        return res;
    endfunction

    // Only a load in EX cannot be bypassed yet: its data appears one stage later.
    assign hazard  = raw_hit(valid_q && wen_q && is_load_q, rd_q);
    assign opa     = fwd(rs1_q, rs1_val_q);
    assign opb_reg = fwd(rs2_q, rs2_val_q);
`else
    logic unused_fwd;

    // Without bypass every in-flight writer must drain past MEM/WB first.
    assign hazard  = raw_hit(valid_q && wen_q, rd_q) ||
                     raw_hit(exm_valid && exm_wen, exm_rd) ||
                     raw_hit(wb_valid && wb_wen, wb_rd);
    assign opa     = rs1_val_q;
    assign opb_reg = rs2_val_q;
    assign unused_fwd = ^{exm_d, wb_data, rs1_q, rs2_q};
`endif

    // Gating with rst_n releases a stall the moment reset asserts, even when the
    // conflicting writer sits in a downstream register this block does not reset.
    assign id_stall = rst_n && id_valid && !flush && hazard;

    always_comb begin
        valid_d   = valid_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        s_d       = s_q;
        cin_d     = cin_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        is_load_d = is_load_q;
        if (flush || id_stall) begin
            // Bubble: only valid matters, payload fields are left as they were.
            valid_d = 1'b0;
        end else begin
            valid_d   = id_valid;
            rs1_d     = id_rs1;
            rs2_d     = id_rs2;
            rs1_val_d = id_rs1_val;
            rs2_val_d = id_rs2_val;
            imm_d     = id_imm;
            use_imm_d = id_use_imm;
            s_d       = id_S;
            cin_d     = id_Cin;
            rd_d      = id_rd;
            wen_d     = id_wen;
            is_load_d = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rs1_val_q <= 32'd0;
            rs2_val_q <= 32'd0;
            imm_q     <= 32'd0;
            use_imm_q <= 1'b0;
            s_q       <= 3'd0;
            cin_q     <= 1'b0;
            rd_q      <= 5'd0;
            wen_q     <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            s_q       <= s_d;
            cin_q     <= cin_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            is_load_q <= is_load_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_a       = opa;
    assign ex_b       = use_imm_q ? imm_q : opb_reg;
    assign ex_S       = s_q;
    assign ex_Cin     = cin_q;
    assign ex_rd      = rd_q;
    assign ex_wen     = valid_q && wen_q;
    assign ex_is_load = valid_q && is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_imm, id_Cin, id_wen, id_is_load, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, wb_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm, exm_d, wb_data;
    logic [2:0]  id_S;
    logic        exm_valid, exm_wen, wb_valid, wb_wen;
    logic        id_stall, ex_valid, ex_Cin, ex_wen, ex_is_load;
    logic [31:0] ex_a, ex_b;
    logic [2:0]  ex_S;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_S(id_S), .id_Cin(id_Cin), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .flush(flush),
        .exm_valid(exm_valid), .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_d(exm_d),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_S(ex_S), .ex_Cin(ex_Cin), .ex_rd(ex_rd), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load)
    );

    // Reference model: the instruction currently sitting in EX.
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2;
        logic [31:0] rs1_val, rs2_val, imm;
        logic        use_imm;
        logic [2:0]  s;
        logic        cin;
        logic [4:0]  rd;
        logic        wen, is_load;
    } ex_t;

    ex_t m;

    function automatic logic model_stall();
        logic       w_ok [3];
        logic [4:0] w_rd [3];
        logic       hit;
`ifdef FWD_EN
        w_ok[0] = m.valid && m.wen && m.is_load;
        w_ok[1] = 1'b0;
        w_ok[2] = 1'b0;
`else
        w_ok[0] = m.valid && m.wen;
        w_ok[1] = exm_valid && exm_wen;
        w_ok[2] = wb_valid && wb_wen;
`endif
        w_rd[0] = m.rd;
        w_rd[1] = exm_rd;
        w_rd[2] = wb_rd;
        hit = 1'b0;
        for (int i = 0; i < 3; i++)
            if (w_ok[i] && w_rd[i] != 0 &&
                (w_rd[i] == id_rs1 || (!id_use_imm && w_rd[i] == id_rs2)))
                hit = 1'b1;
        return rst_n && id_valid && !flush && hit;
    endfunction

    function automatic logic [31:0] model_operand(input logic [4:0] src, input logic [31:0] regv);
`ifdef FWD_EN
        if (src != 0) begin
            if (exm_valid && exm_wen && exm_rd == src) return exm_d;
            if (wb_valid && wb_wen && wb_rd == src) return wb_data;
        end
`endif
        return regv;
    endfunction

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_val = 0; id_rs2_val = 0;
        id_imm = 0; id_use_imm = 0; id_S = 0; id_Cin = 0; id_rd = 0;
        id_wen = 0; id_is_load = 0; flush = 0;
        exm_valid = 0; exm_wen = 0; exm_rd = 0; exm_d = 0;
        wb_valid = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic random_inputs();
        id_valid   = ($urandom_range(0, 3) != 0);
        id_rs1     = 5'($urandom_range(0, 3));
        id_rs2     = 5'($urandom_range(0, 3));
        id_rs1_val = $urandom;
        id_rs2_val = $urandom;
        id_imm     = $urandom;
        id_use_imm = 1'($urandom_range(0, 1));
        id_S       = 3'($urandom_range(0, 7));
        id_Cin     = 1'($urandom_range(0, 1));
        id_rd      = 5'($urandom_range(0, 3));
        id_wen     = 1'($urandom_range(0, 1));
        id_is_load = ($urandom_range(0, 2) == 0);
        flush      = ($urandom_range(0, 7) == 0);
        exm_valid  = 1'($urandom_range(0, 1));
        exm_wen    = 1'($urandom_range(0, 1));
        exm_rd     = 5'($urandom_range(0, 3));
        exm_d      = $urandom;
        wb_valid   = 1'($urandom_range(0, 1));
        wb_wen     = 1'($urandom_range(0, 1));
        wb_rd      = 5'($urandom_range(0, 3));
        wb_data    = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            random_inputs();
            #1;
            checks++;
            if ({id_stall, ex_valid, ex_a, ex_b, ex_S, ex_Cin, ex_rd, ex_wen, ex_is_load} !== '0) begin
                errs++;
                $display("FAIL reset_outputs: stall=%b valid=%b a=%h b=%h S=%h Cin=%b rd=%0d wen=%b ld=%b, required all 0",
                         id_stall, ex_valid, ex_a, ex_b, ex_S, ex_Cin, ex_rd, ex_wen, ex_is_load);
            end
            next_cycle();
        end
        idle_inputs();
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        id_valid = 1; id_rs1 = 1; id_rs1_val = 5; id_imm = 7; id_use_imm = 1;
        id_S = 3'd0; id_Cin = 0; id_rd = 2; id_wen = 1;
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if ({ex_valid, ex_a, ex_b, ex_S, ex_Cin, ex_rd, ex_wen} !== {1'b1, 32'd5, 32'd7, 3'd0, 1'b0, 5'd2, 1'b1}) begin
            errs++;
            $display("FAIL basic: valid=%b a=%0d b=%0d S=%0d Cin=%b rd=%0d wen=%b, required 1 5 7 0 0 2 1",
                     ex_valid, ex_a, ex_b, ex_S, ex_Cin, ex_rd, ex_wen);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] exp;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle_inputs();
            id_valid = 1; id_rs1 = (k == 0) ? 5'd3 : 5'd0;
            id_rs1_val = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
            id_use_imm = 1; id_imm = 32'h55;
            next_cycle();
            id_valid = 0;
            exm_valid = 1; exm_wen = 1; exm_rd = (k == 0) ? 5'd3 : 5'd0; exm_d = 32'hDEAD_BEEF;
            #1;
`ifdef FWD_EN
            exp = (k == 0) ? 32'hDEAD_BEEF : 32'h2222_2222;
`else
            exp = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
`endif
            checks++;
            if (ex_a !== exp) begin
                errs++;
                $display("FAIL fwd_exm_rs1_case%0d: ex_a=%h required %h", k, ex_a, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        logic [31:0] exp;
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rs2 = 4; id_rs2_val = 32'h33; id_use_imm = 0;
        next_cycle();
        id_valid = 0;
        exm_valid = 1; exm_wen = 1; exm_rd = 4; exm_d = 1;
        wb_valid = 1; wb_wen = 1; wb_rd = 4; wb_data = 2;
        #1;
`ifdef FWD_EN
        exp = 32'd1;
`else
        exp = 32'h33;
`endif
        checks++;
        if (ex_b !== exp) begin
            errs++;
            $display("FAIL priority_exm_over_wb: ex_b=%h required %h", ex_b, exp);
        end
        exm_valid = 0;
        #1;
`ifdef FWD_EN
        exp = 32'd2;
`endif
        checks++;
        if (ex_b !== exp) begin
            errs++;
            $display("FAIL fwd_wb_only: ex_b=%h required %h", ex_b, exp);
        end
        idle_inputs();
    endtask

    // Puts a load with rd=5 into EX and presents a reader of rs1=5 in ID.
    task automatic setup_load_use();
        @(negedge clk);
        idle_inputs();
        id_valid = 1; id_rd = 5; id_wen = 1; id_is_load = 1; id_use_imm = 1;
        next_cycle();
        id_is_load = 0; id_rd = 7; id_rs1 = 5; id_rs1_val = 32'h999;
        id_use_imm = 1; id_imm = 32'h10;
    endtask

    task automatic test_load_use();
`ifdef FWD_EN
        setup_load_use();
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            errs++;
            $display("FAIL load_use_stall: id_stall=%b required 1", id_stall);
        end
        next_cycle();
        exm_valid = 1; exm_wen = 1; exm_rd = 5; exm_d = 32'hBAD0;
        #1;
        checks++;
        if ({ex_valid, id_stall} !== 2'b00) begin
            errs++;
            $display("FAIL load_use_bubble: ex_valid=%b id_stall=%b required 0 0", ex_valid, id_stall);
        end
        next_cycle();
        id_valid = 0; exm_valid = 0;
        wb_valid = 1; wb_wen = 1; wb_rd = 5; wb_data = 32'h1234;
        #1;
        checks++;
        if ({ex_valid, ex_a} !== {1'b1, 32'h1234}) begin
            errs++;
            $display("FAIL load_use_data: ex_valid=%b ex_a=%h required 1 00001234", ex_valid, ex_a);
        end
        idle_inputs();
`endif
    endtask

    task automatic test_flush_stall();
        setup_load_use();
        flush = 1;
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            errs++;
            $display("FAIL flush_stall_id_stall: id_stall=%b required 0", id_stall);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (ex_valid !== 1'b0) begin
            errs++;
            $display("FAIL flush_stall_ex_valid: ex_valid=%b required 0", ex_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        setup_load_use();
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            errs++;
            $display("FAIL mid_stall_pre: id_stall=%b required 1", id_stall);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({id_stall, ex_valid} !== 2'b00) begin
            errs++;
            $display("FAIL mid_stall_reset: id_stall=%b ex_valid=%b required 0 0", id_stall, ex_valid);
        end
        #1 rst_n = 1;
        next_cycle();
        id_valid = 0;
        #1;
        checks++;
        if ({ex_valid, ex_a} !== {1'b1, 32'h999}) begin
            errs++;
            $display("FAIL mid_stall_release: ex_valid=%b ex_a=%h required 1 00000999", ex_valid, ex_a);
        end
        idle_inputs();
    endtask

    // ALU writer rd=6 then a reader of rs2=6; the bench shifts EX outputs through
    // its own EX/MEM and MEM/WB registers so the writer drains naturally.
    task automatic test_raw_alu();
        localparam logic [31:0] RES = 32'h600D_0006;
        logic pv_exm, pw_exm, pv_wb, pw_wb, cv, cw;
        logic [4:0] prd_exm, prd_wb, crd;
        int stalls;
        logic entered;
        logic [31:0] exp;
        do_reset();
        pv_exm = 0; pw_exm = 0; prd_exm = 0; pv_wb = 0; pw_wb = 0; prd_wb = 0;
        id_valid = 1; id_rd = 6; id_wen = 1; id_use_imm = 1; id_imm = 32'h6;
        next_cycle();
        stalls = 0;
        entered = 0;
        for (int k = 0; k < 8 && !entered; k++) begin
            id_valid = 1; id_rs1 = 0; id_rs2 = 6; id_use_imm = 0; id_rd = 9; id_wen = 1;
            id_rs2_val = 32'h0000_CAFE;
            exm_valid = pv_exm; exm_wen = pw_exm; exm_rd = prd_exm; exm_d = RES;
            wb_valid = pv_wb; wb_wen = pw_wb; wb_rd = prd_wb; wb_data = RES;
            #1;
            if (id_stall) stalls++;
            else entered = 1;
            cv = ex_valid; cw = ex_wen; crd = ex_rd;
            @(posedge clk);
            pv_wb = pv_exm; pw_wb = pw_exm; prd_wb = prd_exm;
            pv_exm = cv; pw_exm = cw; prd_exm = crd;
            @(negedge clk);
        end
        id_valid = 0;
        exm_valid = pv_exm; exm_wen = pw_exm; exm_rd = prd_exm;
        wb_valid = pv_wb; wb_wen = pw_wb; wb_rd = prd_wb;
        #1;
`ifdef FWD_EN
        checks++;
        if (stalls !== 0) begin
            errs++;
            $display("FAIL raw_alu_stalls: %0d stall cycles, required 0", stalls);
        end
        exp = RES;
`else
        checks++;
        if (stalls !== 3) begin
            errs++;
            $display("FAIL raw_alu_stalls: %0d stall cycles, required 3", stalls);
        end
        exp = 32'h0000_CAFE;
`endif
        checks++;
        if ({entered, ex_valid, ex_b} !== {1'b1, 1'b1, exp}) begin
            errs++;
            $display("FAIL raw_alu_operand: entered=%b ex_valid=%b ex_b=%h required 1 1 %h",
                     entered, ex_valid, ex_b, exp);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        ex_t nxt;
        logic exp_stall;
        logic [31:0] ea, eb;
        do_reset();
        m = '0;
        for (int c = 0; c < 400; c++) begin
            random_inputs();
            #1;
            exp_stall = model_stall();
            checks++;
            if (id_stall !== exp_stall) begin
                errs++;
                $display("FAIL rand_stall cyc%0d: id_stall=%b required %b", c, id_stall, exp_stall);
            end
            checks++;
            if ({ex_valid, ex_wen, ex_is_load} !== {m.valid, m.valid & m.wen, m.valid & m.is_load}) begin
                errs++;
                $display("FAIL rand_ctrl cyc%0d: valid/wen/ld=%b%b%b required %b%b%b", c,
                         ex_valid, ex_wen, ex_is_load, m.valid, m.valid & m.wen, m.valid & m.is_load);
            end
            if (m.valid) begin
                ea = model_operand(m.rs1, m.rs1_val);
                eb = m.use_imm ? m.imm : model_operand(m.rs2, m.rs2_val);
                checks++;
                if ({ex_a, ex_b, ex_S, ex_Cin, ex_rd} !== {ea, eb, m.s, m.cin, m.rd}) begin
                    errs++;
                    $display("FAIL rand_data cyc%0d: a=%h b=%h S=%0d Cin=%b rd=%0d required %h %h %0d %b %0d",
                             c, ex_a, ex_b, ex_S, ex_Cin, ex_rd, ea, eb, m.s, m.cin, m.rd);
                end
            end
            nxt = m;
            if (flush || exp_stall) nxt.valid = 1'b0;
            else nxt = '{id_valid, id_rs1, id_rs2, id_rs1_val, id_rs2_val, id_imm,
                         id_use_imm, id_S, id_Cin, id_rd, id_wen, id_is_load};
            @(posedge clk);
            m = nxt;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_forwarding();
        test_priority();
        test_load_use();
        test_flush_stall();
        test_reset_mid_stall();
        test_raw_alu();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
